// File: rtl/fc_sequencer.sv
// ============================================================================
// Module   : fc_sequencer
// Purpose  : Time-multiplexed 10x10 fully connected layer built around one
//            signed MAC. Weights are fetched row-major over a req/gnt port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fc_sequencer #(
    parameter int bitwidth = 8,
    parameter int accwidth = 2*bitwidth+4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [bitwidth-1:0] featuremap3 [0:9],
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    output logic                       weight_req,
    output logic [6:0]                 weight_addr,
    input  logic                       weight_gnt,
    input  logic signed [bitwidth-1:0] weight_rdata,
    output logic signed [bitwidth-1:0] output_vector [0:9]
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                      r_state;
    logic [3:0]                  r_i;
    logic [3:0]                  r_j;
    logic [3:0]                  r_i_d;
    logic                        r_rd_valid;
    logic signed [accwidth-1:0]  r_acc;
    logic signed [bitwidth-1:0]  r_feat [0:9];

    logic signed [2*bitwidth-1:0] w_prod;
    logic signed [accwidth-1:0]   w_prod_ext;

    assign w_prod     = r_feat[r_i_d] * weight_rdata;
    assign w_prod_ext = {{(accwidth-2*bitwidth){w_prod[2*bitwidth-1]}}, w_prod};
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_i         <= 4'd0;
            r_j         <= 4'd0;
            r_i_d       <= 4'd0;
            r_rd_valid  <= 1'b0;
            r_acc       <= '0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            weight_req  <= 1'b0;
            weight_addr <= 7'd0;
            for (int k = 0; k < 10; k++) begin
                r_feat[k]        <= '0;
                output_vector[k] <= '0;
            end
        end else begin
            done       <= 1'b0;
            r_rd_valid <= weight_req && weight_gnt;
            r_i_d      <= r_i;
            // Product of the weight accepted last cycle; data arrives one cycle late.
            if (r_rd_valid) begin
                r_acc <= r_acc + w_prod_ext;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 10; k++) begin
                            r_feat[k] <= featuremap3[k];
                        end
                        out_valid   <= 1'b0;
                        r_i         <= 4'd0;
                        r_j         <= 4'd0;
                        r_acc       <= '0;
                        weight_addr <= 7'd0;
                        weight_req  <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Row-major order makes the address a plain running count.
                    if (weight_gnt) begin
                        r_i         <= r_i + 4'd1;
                        weight_addr <= weight_addr + 7'd1;
                        if (r_i == 4'd9) begin
                            weight_req <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    output_vector[r_j] <= r_acc[bitwidth+6:7];
                    r_acc <= '0;
                    r_i   <= 4'd0;
                    if (r_j == 4'd9) begin
                        done      <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_j        <= r_j + 4'd1;
                        weight_req <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_sequencer.sv
// ============================================================================
// Module   : tb_fc_sequencer
// Purpose  : Directed and randomized checks of fc_sequencer against a
//            matrix-vector reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fc_sequencer;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              weight_gnt = 1'b0;
    logic signed [7:0] weight_rdata = 8'sd0;
    logic signed [7:0] fm [0:9];
    logic signed [7:0] ov [0:9];
    logic              busy, done, out_valid, weight_req;
    logic [6:0]        weight_addr;

    logic signed [7:0] mem [0:99];
    int n_assert = 0;
    int n_fail   = 0;

    fc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .featuremap3   (fm),
        .busy          (busy),
        .done          (done),
        .out_valid     (out_valid),
        .weight_req    (weight_req),
        .weight_addr   (weight_addr),
        .weight_gnt    (weight_gnt),
        .weight_rdata  (weight_rdata),
        .output_vector (ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: y[j] = floor(sum_i f[i]*W[j][i] / 128), kept to 8 bits.
    function automatic logic [7:0] model(input int j);
        int s = 0;
        for (int i = 0; i < 10; i++) s += int'(fm[i]) * int'(mem[j*10+i]);
        return 8'(s >>> 7);
    endfunction

    function automatic logic gnt_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2) == 1;
        return ($urandom % 3) != 0;
    endfunction

    task automatic set_fill(input int f, input int w, input bit diag);
        for (int i = 0; i < 10; i++) fm[i] = 8'(f);
        for (int j = 0; j < 10; j++)
            for (int i = 0; i < 10; i++)
                mem[j*10+i] = (!diag || i == j) ? 8'(w) : 8'sd0;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 10; i++) fm[i] = 8'($urandom);
        for (int k = 0; k < 100; k++) mem[k] = 8'($urandom);
    endtask

    task automatic run_vec(input int mode, input int abort_at, input int poke_at, input string tag);
        int cycles = 0, stalls = 0, exp_addr = 0;
        int addr_err = 0, hold_err = 0, busy_err = 0, nz = 0;
        logic acc_now, prev_stall = 1'b0;
        logic [6:0] a, prev_addr = 7'd0;
        bit fin = 0;

        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        @(posedge clk); #1;
        start        = 1'b0;
        weight_gnt   = gnt_for(mode, 1);
        weight_rdata = 8'($urandom);

        while (cycles < 2000 && !fin) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                fin = 1;
            end else begin
                if (!busy) busy_err++;
                acc_now = weight_req && weight_gnt;
                a = weight_addr;
                if (prev_stall && weight_req && a !== prev_addr) hold_err++;
                prev_stall = weight_req && !weight_gnt;
                prev_addr  = a;
                if (prev_stall) stalls++;
                if (acc_now) begin
                    if (a !== exp_addr[6:0]) addr_err++;
                    exp_addr++;
                end
                if (cycles == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk({tag, "_rst_busy"}, busy, 0);
                    chk({tag, "_rst_done"}, done, 0);
                    chk({tag, "_rst_outvalid"}, out_valid, 0);
                    chk({tag, "_rst_req"}, weight_req, 0);
                    chk({tag, "_rst_addr"}, weight_addr, 0);
                    for (int j = 0; j < 10; j++) if (ov[j] !== 8'sd0) nz++;
                    chk({tag, "_rst_outputs_nonzero"}, nz, 0);
                    weight_gnt = 1'b0;
                    start      = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                @(posedge clk); #1;
                start        = (cycles == poke_at);
                weight_rdata = acc_now ? mem[a] : 8'($urandom);
                weight_gnt   = gnt_for(mode, cycles + 1);
            end
        end
        start = 1'b0;

        chk({tag, "_done_seen"}, fin, 1);
        chk({tag, "_done_cycle"}, cycles, 121 + stalls);
        chk({tag, "_busy_at_done"}, busy, 1);
        chk({tag, "_outvalid_at_done"}, out_valid, 1);
        chk({tag, "_addr_order_errs"}, addr_err, 0);
        chk({tag, "_accept_count"}, exp_addr, 100);
        chk({tag, "_addr_hold_errs"}, hold_err, 0);
        chk({tag, "_busy_drop_errs"}, busy_err, 0);
        for (int j = 0; j < 10; j++)
            chk($sformatf("%s_out%0d", tag, j), 32'($signed(ov[j])), 32'($signed(model(j))));
    endtask

    task automatic idle_watch(input int n, input string tag);
        int bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        chk({tag, "_idle_activity"}, bad, 0);
    endtask

    initial begin
        set_fill(0, 0, 0);
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_outvalid", out_valid, 0);
        chk("reset_req", weight_req, 0);
        chk("reset_addr", weight_addr, 0);
        chk("reset_out0", ov[0], 0);
        chk("reset_out9", ov[9], 0);
        @(negedge clk);
        rst_n = 1'b1;

        set_fill(1, 1, 0);        run_vec(0, 0, 0, "ones");
        set_fill(127, 127, 0);    run_vec(0, 0, 0, "max");
        set_fill(-128, -128, 1);  run_vec(0, 0, 0, "negdiag");
        set_fill(-128, -128, 0);  run_vec(0, 0, 0, "negfull");
        set_fill(64, 127, 1);     run_vec(1, 0, 0, "floor_toggle");
        set_fill(-128, 127, 1);   run_vec(0, 0, 0, "negfloor");
        set_rand();               run_vec(1, 0, 0, "rand_toggle");
        set_rand();               run_vec(2, 0, 0, "rand_gnt");
        set_rand();               run_vec(2, 0, 30, "rand_poke");
        idle_watch(40, "after_poke");
        set_rand();               run_vec(0, 50, 0, "abort");
        idle_watch(5, "after_abort");
        set_rand();               run_vec(2, 0, 0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fc_sequencer.md
Name: fc_sequencer

Overview:
- Time-multiplexed controller for the 10x10 fully connected stage: one signed MAC reused 100 times instead of 100 parallel multipliers.
- Latches the 10-element feature vector (featuremap3) on start.
- Fetches weights row-major from a shared weight memory over a req/gnt read port.
- Accumulates each row, then writes the scaled, truncated result into a 10-entry output vector.
- Sits between the last pooling stage and the classifier output.

Parameters:
- bitwidth, 8, signed width of features, weights and outputs.
- accwidth, 2*bitwidth+4, signed accumulator width; holds 10*(-2^(bitwidth-1))^2 without overflow.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new vector computation; sampled only in IDLE
- featuremap3  input  [bitwidth-1:0] x10 signed  input vector; captured on start-accept edge
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when all 10 outputs are written
- out_valid  output  1  output_vector holds a complete result
- weight_req  output  1  weight read request
- weight_addr  output  7  weight index j*10+i (row j = output, col i = input)
- weight_gnt  input  1  request accepted this cycle (weight_req && weight_gnt)
- weight_rdata  input  [bitwidth-1:0] signed  weight data; valid exactly 1 cycle after acceptance
- output_vector  output  [bitwidth-1:0] x10 signed  results, registered

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, out_valid and weight_req all 0.
  - weight_addr=0, output_vector all 0, accumulator 0, feature latch 0, counters j=i=0.
  - Reset mid-operation aborts immediately: no done, partial results discarded.
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - On start=1: latch featuremap3, clear out_valid, set j=i=0, acc=0, go to RUN.
  - start asserted in any other state is ignored; no queuing.
- RUN:
  - weight_req=1, weight_addr=j*10+i.
  - On weight_gnt: i increments. If i==9, go to DRAIN; else stay.
  - Without gnt, address and i hold.
- Accumulate:
  - rd_valid is a register equal to last cycle's (req&&gnt). It also latches the matching i.
  - On rd_valid: acc += sign-extended feature[i_d] * weight_rdata, full-precision signed.
- DRAIN:
  - weight_req=0.
  - Absorbs the final product of the row; always 1 cycle.
- WRITE:
  - output_vector[j] <= acc[bitwidth+6:7], i.e. arithmetic shift right by 7, truncated to bitwidth (wraps, no saturation).
  - acc<=0, i<=0.
  - If j==9, go to DONE; else j++ and return to RUN.
- DONE:
  - done=1 for exactly this cycle, out_valid<=1, then IDLE.
- Timing:
  - With weight_gnt tied high, each row takes 12 cycles (10 RUN, 1 DRAIN, 1 WRITE).
  - done is high in the 121st cycle after the start-accept edge.
  - Each gnt-low cycle in RUN adds exactly one cycle.
- output_vector entries update only in WRITE. Entries of rows not yet rewritten keep prior values; consumers rely on out_valid.
- weight_rdata is ignored when rd_valid=0.
- Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.

Test Plan:
- All features=1, all weights=1, gnt=1 -> each acc=10, output_vector all 0. done pulses in the 121st cycle after start. weight_addr sweeps 0..99 in order, each once.
- Features all 127, weights all 127 -> acc=161290 -> bits[14:7]=236 -> every output=-20 (truncation wrap check).
- Features all -128, weights diagonal -128 else 0 -> acc=16384 -> output 128 wraps to -128. Confirms accwidth has no intermediate overflow (all-(-128) weights give acc=163840, not corrupted).
- Features 64, weight diagonal 127 -> 63 (floor); features -128, diagonal 127 -> -127.
- weight_gnt toggling 1,0,1,0... -> identical results to the gnt=1 run. Address holds across gnt-low cycles. done delayed by the number of gnt-low RUN cycles.
- Reset at cycle 50 of a run:
  - busy, done and out_valid drop asynchronously, output_vector clears.
  - A new start then completes normally.
  - A start pulse while busy is ignored, with no second done.
